// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-counter family.
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Prescaler counter width; at least one bit so the register is always legal.
  function automatic int pcnt_w(input int p);
    return (clog2(p) < 1) ? 1 : clog2(p);
  endfunction
endpackage

// File: rtl/count_prescaler.sv
// Divides the count enable by PRESCALE; step is combinational so tc can chain same-cycle.
module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, restart};
    assign step     = en;
  end else begin : g_div
    localparam int PW = pcnt_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] r_pcnt;

    assign step = en & (r_pcnt == LAST);

    always_ff @(posedge clk) begin
      if (reset || restart) r_pcnt <= '0;
      else if (en)          r_pcnt <= step ? '0 : r_pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/param_mod_counter.sv
// Up/down modulo counter with prescaled enable, clamped load, wrap/saturate and cascade outputs.
module param_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MOD_MAX   = 2**WIDTH - 1,
  parameter int PRESCALE  = 1,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             at_bound
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q, w_q_nxt, w_ld_val;
  logic             r_wrap, r_at_bound;
  logic             w_step, w_wrap_nxt, w_oor;

  count_prescaler #(.PRESCALE(PRESCALE)) u_ps (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clr | load),
    .step    (w_step)
  );

  // With a full-range modulus no value can exceed MOD_MAX, so the compares vanish.
  if (MOD_MAX == 2**WIDTH - 1) begin : g_full
    assign w_ld_val = load_val;
    assign w_oor    = 1'b0;
  end else begin : g_part
    assign w_ld_val = (load_val > MAXV) ? MAXV : load_val;
    assign w_oor    = (r_q > MAXV);
  end

  assign tc = w_step & ((up == DIR_UP) ? (r_q == MAXV) : (r_q == '0));

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (reset || clr) begin
      w_q_nxt = RSTV;
    end else if (load) begin
      w_q_nxt = w_ld_val;
    end else if (w_step) begin
      if (up == DIR_UP) begin
        if (r_q == MAXV || w_oor) begin
          w_q_nxt    = SATURATE ? MAXV : '0;
          w_wrap_nxt = ~SATURATE;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_q_nxt    = SATURATE ? '0 : MAXV;
          w_wrap_nxt = ~SATURATE;
        end else if (w_oor) begin
          w_q_nxt = MAXV;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    r_q        <= w_q_nxt;
    r_wrap     <= w_wrap_nxt;
    r_at_bound <= (up == DIR_DN) ? (w_q_nxt == '0) : (w_q_nxt == MAXV);
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign at_bound = r_at_bound;

endmodule

// File: tb/tb_param_mod_counter.sv
// Randomized + directed bench: five counters (default, prescaled, saturating, BCD cascade pair).
module tb_param_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Input groups 0..3; instance 4 (cascade upper) shares group 3 except en.
  logic       rst;
  logic       en [4], up [4], clr [4], ld [4];
  logic [3:0] lv [4];

  logic [3:0] q_o  [5];
  logic       tc_o [5], wrap_o [5], ab_o [5];

  param_mod_counter u0 (
    .clk(clk), .reset(rst), .en(en[0]), .up(up[0]), .clr(clr[0]), .load(ld[0]), .load_val(lv[0]),
    .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .at_bound(ab_o[0]));
  param_mod_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(4)) u1 (
    .clk(clk), .reset(rst), .en(en[1]), .up(up[1]), .clr(clr[1]), .load(ld[1]), .load_val(lv[1]),
    .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .at_bound(ab_o[1]));
  param_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1), .RESET_VAL(5)) u2 (
    .clk(clk), .reset(rst), .en(en[2]), .up(up[2]), .clr(clr[2]), .load(ld[2]), .load_val(lv[2]),
    .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .at_bound(ab_o[2]));
  param_mod_counter #(.WIDTH(4), .MOD_MAX(9)) u_lo (
    .clk(clk), .reset(rst), .en(en[3]), .up(up[3]), .clr(clr[3]), .load(ld[3]), .load_val(lv[3]),
    .q(q_o[3]), .tc(tc_o[3]), .wrap(wrap_o[3]), .at_bound(ab_o[3]));
  param_mod_counter #(.WIDTH(4), .MOD_MAX(9)) u_hi (
    .clk(clk), .reset(rst), .en(tc_o[3]), .up(up[3]), .clr(clr[3]), .load(ld[3]), .load_val(lv[3]),
    .q(q_o[4]), .tc(tc_o[4]), .wrap(wrap_o[4]), .at_bound(ab_o[4]));

  // Model configuration per instance.
  int M  [5] = '{15, 9, 9, 9, 9};
  int P  [5] = '{1, 4, 1, 1, 1};
  bit S  [5] = '{0, 0, 1, 0, 0};
  int RV [5] = '{0, 0, 5, 0, 0};

  int mq [5], mpc [5];
  bit mw [5], mab [5];
  int n_pass = 0, n_tot = 0, cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  function automatic int grp(input int i);
    return (i == 4) ? 3 : i;
  endfunction

  function automatic bit mtc(input int i, input bit e);
    int g;
    g = grp(i);
    return e && (mpc[i] == P[i] - 1) && (up[g] ? (mq[i] == M[i]) : (mq[i] == 0));
  endfunction

  function automatic bit men(input int i);
    return (i == 4) ? mtc(3, en[3]) : en[i];
  endfunction

  task automatic model_step(input int i, input bit e);
    int g;
    bit wr;
    g  = grp(i);
    wr = 1'b0;
    if (rst || clr[g]) begin
      mq[i] = RV[i]; mpc[i] = 0;
    end else if (ld[g]) begin
      mq[i] = (int'(lv[g]) > M[i]) ? M[i] : int'(lv[g]); mpc[i] = 0;
    end else if (e) begin
      if (mpc[i] == P[i] - 1) begin
        mpc[i] = 0;
        if (up[g]) begin
          if (mq[i] == M[i]) begin if (!S[i]) begin mq[i] = 0; wr = 1'b1; end end
          else mq[i] = mq[i] + 1;
        end else begin
          if (mq[i] == 0) begin if (!S[i]) begin mq[i] = M[i]; wr = 1'b1; end end
          else mq[i] = mq[i] - 1;
        end
      end else begin
        mpc[i] = mpc[i] + 1;
      end
    end
    mw[i]  = wr;
    mab[i] = up[g] ? (mq[i] == M[i]) : (mq[i] == 0);
  endtask

  // One clock: advance the model on the edge, then compare every output at the falling edge.
  task automatic tick();
    bit e [5];
    @(posedge clk);
    for (int i = 0; i < 5; i++) e[i] = men(i);
    for (int i = 0; i < 5; i++) model_step(i, e[i]);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("q[%0d]", i),        int'(q_o[i]),    mq[i]);
      chk($sformatf("wrap[%0d]", i),     int'(wrap_o[i]), int'(mw[i]));
      chk($sformatf("at_bound[%0d]", i), int'(ab_o[i]),   int'(mab[i]));
      chk($sformatf("tc[%0d]", i),       int'(tc_o[i]),   int'(mtc(i, men(i))));
    end
  endtask

  task automatic idle();
    for (int g = 0; g < 4; g++) begin
      en[g] = 0; clr[g] = 0; ld[g] = 0; lv[g] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) up[g] = 1'b1;
    idle();
    tick();
    chk("lit_reset_q0", int'(q_o[0]), 0);
    chk("lit_reset_q2", int'(q_o[2]), 5);
    rst = 1'b0;

    // Default counter: 0..15 then wrap.
    en[0] = 1;
    repeat (15) tick();
    chk("lit_q0_15", int'(q_o[0]), 15);
    chk("lit_tc0_at15", int'(tc_o[0]), 1);
    tick();
    chk("lit_q0_wrap0", int'(q_o[0]), 0);
    chk("lit_wrap0", int'(wrap_o[0]), 1);
    tick();
    chk("lit_wrap0_pulse", int'(wrap_o[0]), 0);
    en[0] = 0;

    // Prescale by 4, then freeze.
    en[1] = 1;
    repeat (12) tick();
    chk("lit_ps_q3", int'(q_o[1]), 3);
    en[1] = 0;
    repeat (5) tick();
    chk("lit_ps_frozen", int'(q_o[1]), 3);
    en[1] = 1;
    repeat (3) tick();
    chk("lit_ps_phase", int'(q_o[1]), 3);
    tick();
    chk("lit_ps_q4", int'(q_o[1]), 4);
    en[1] = 0;

    // Saturating counter.
    ld[2] = 1; lv[2] = 8; tick();
    ld[2] = 0; en[2] = 1; up[2] = 1; tick();
    chk("lit_sat_q9", int'(q_o[2]), 9);
    repeat (3) tick();
    chk("lit_sat_hold9", int'(q_o[2]), 9);
    chk("lit_sat_nowrap", int'(wrap_o[2]), 0);
    en[2] = 0; ld[2] = 1; lv[2] = 1; tick();
    ld[2] = 0; en[2] = 1; up[2] = 0; tick(); tick();
    chk("lit_sat_hold0", int'(q_o[2]), 0);
    en[2] = 0; clr[2] = 1; ld[2] = 1; lv[2] = 7; tick();
    chk("lit_clr_over_load", int'(q_o[2]), 5);
    idle();

    // Clamped load beats step; then down-wrap from 0.
    ld[3] = 1; lv[3] = 12; en[3] = 1; up[3] = 1; tick();
    chk("lit_load_clamp", int'(q_o[3]), 9);
    ld[3] = 0; en[3] = 0; clr[3] = 1; tick();
    clr[3] = 0; en[3] = 1; up[3] = 0; tick();
    chk("lit_dn_wrap_q9", int'(q_o[3]), 9);
    chk("lit_dn_wrap", int'(wrap_o[3]), 1);
    tick();
    chk("lit_dn_q8", int'(q_o[3]), 8);
    en[3] = 0; clr[3] = 1; tick();
    clr[3] = 0;

    // BCD cascade 00..99..00, reset at 57.
    en[3] = 1; up[3] = 1;
    repeat (99) tick();
    chk("lit_casc_99", int'(q_o[4]) * 10 + int'(q_o[3]), 99);
    tick();
    chk("lit_casc_00", int'(q_o[4]) * 10 + int'(q_o[3]), 0);
    chk("lit_casc_hi_wrap", int'(wrap_o[4]), 1);
    repeat (57) tick();
    chk("lit_casc_57", int'(q_o[4]) * 10 + int'(q_o[3]), 57);
    rst = 1; tick();
    chk("lit_casc_rst", int'(q_o[4]) * 10 + int'(q_o[3]), 0);
    rst = 0;

    // Randomized traffic against the model.
    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int g = 0; g < 4; g++) begin
        en[g]  = ($urandom_range(0, 3) != 0);
        clr[g] = ($urandom_range(0, 39) == 0);
        ld[g]  = ($urandom_range(0, 19) == 0);
        lv[g]  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) up[g] = ~up[g];
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
